// File: rtl/ipv4_rx.sv
// rtl/ipv4_rx.sv - receive-side Ethernet/IPv4 header parser with UDP payload forwarding
module ipv4_rx #(
   parameter logic [47:0] LOCAL_MAC = 48'h000a3501fec0,
   parameter logic [31:0] LOCAL_IP  = 32'hc0a80002
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_dv,
   output logic [3:0]  ip_ver,
   output logic [3:0]  ip_hdr_len,
   output logic [7:0]  ip_tos,
   output logic [15:0] ip_total_len,
   output logic [15:0] ip_id,
   output logic        ip_rsv,
   output logic        ip_df,
   output logic        ip_mf,
   output logic [12:0] ip_frag_offset,
   output logic [7:0]  ip_ttl,
   output logic [7:0]  ip_protocol,
   output logic [31:0] src_ip,
   output logic [31:0] dst_ip,
   output logic [47:0] src_mac,
   output logic        cal_en,
   input  logic [15:0] check_sum,
   output logic        hdr_ok,
   output logic        hdr_err,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last
);
   typedef enum logic [2:0] {IDLE, ETH_HDR, IP_HDR, CHK_CAL, CHK_CMP, PAYLOAD, WAIT_END} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic [47:0] dst_mac;
   logic [7:0]  eth_type_hi;
   logic [15:0] rx_csum;
   logic [15:0] pl_rem;
   logic [7:0]  pipe_d1;
   logic        dv_q;
   logic        start, eth_ok, hdr_pass, pl_start;

   // dv_q resets high so a frame already running at reset release is skipped
   assign start    = rx_dv & ~dv_q;
   assign eth_ok   = ((dst_mac == LOCAL_MAC) || (dst_mac == 48'hffffffffffff)) &&
                     ({eth_type_hi, rx_data} == 16'h0800);
   assign hdr_pass = (check_sum == rx_csum) && (ip_ver == 4'd4) && (ip_hdr_len == 4'd5) &&
                     (dst_ip == LOCAL_IP) && (ip_protocol == 8'd17) && !ip_mf &&
                     (ip_frag_offset == 13'd0) && (ip_total_len >= 16'd28);
   assign pl_start = (state == CHK_CMP) && hdr_pass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = ETH_HDR;
         ETH_HDR:  if (!rx_dv) state_nxt = IDLE;
                   else if (cnt == 6'd13) state_nxt = eth_ok ? IP_HDR : WAIT_END;
         IP_HDR:   if (!rx_dv) state_nxt = IDLE;
                   else if (cnt == 6'd33) state_nxt = CHK_CAL;
         CHK_CAL:  state_nxt = CHK_CMP;
         CHK_CMP:  if (!rx_dv) state_nxt = IDLE;
                   else state_nxt = hdr_pass ? PAYLOAD : WAIT_END;
         PAYLOAD:  if (!rx_dv) state_nxt = IDLE;
                   else if (!payload_valid || payload_last) state_nxt = WAIT_END;
         WAIT_END: if (!rx_dv) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cal_en = 1'b0;
      if (state == CHK_CAL) cal_en = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q           <= 1'b1;
         cnt            <= 6'd0;
         dst_mac        <= 48'd0;
         eth_type_hi    <= 8'd0;
         src_mac        <= 48'd0;
         rx_csum        <= 16'd0;
         ip_ver         <= 4'd0;
         ip_hdr_len     <= 4'd0;
         ip_tos         <= 8'd0;
         ip_total_len   <= 16'd0;
         ip_id          <= 16'd0;
         ip_rsv         <= 1'b0;
         ip_df          <= 1'b0;
         ip_mf          <= 1'b0;
         ip_frag_offset <= 13'd0;
         ip_ttl         <= 8'd0;
         ip_protocol    <= 8'd0;
         src_ip         <= 32'd0;
         dst_ip         <= 32'd0;
      end else begin
         dv_q <= rx_dv;
         if (state == IDLE) begin
            cnt <= 6'd1;
            if (start) dst_mac <= {dst_mac[39:0], rx_data};
         end else if ((state == ETH_HDR || state == IP_HDR) && rx_dv) begin
            cnt <= cnt + 6'd1;
            if (cnt < 6'd6)       dst_mac     <= {dst_mac[39:0], rx_data};
            else if (cnt < 6'd12) src_mac     <= {src_mac[39:0], rx_data};
            else if (cnt == 6'd12) eth_type_hi <= rx_data;
         end
         if (state == IP_HDR && rx_dv) begin
            case (cnt)
               6'd14: {ip_ver, ip_hdr_len} <= rx_data;
               6'd15: ip_tos <= rx_data;
               6'd16: ip_total_len[15:8] <= rx_data;
               6'd17: ip_total_len[7:0] <= rx_data;
               6'd18: ip_id[15:8] <= rx_data;
               6'd19: ip_id[7:0] <= rx_data;
               6'd20: {ip_rsv, ip_df, ip_mf, ip_frag_offset[12:8]} <= rx_data;
               6'd21: ip_frag_offset[7:0] <= rx_data;
               6'd22: ip_ttl <= rx_data;
               6'd23: ip_protocol <= rx_data;
               6'd24: rx_csum[15:8] <= rx_data;
               6'd25: rx_csum[7:0] <= rx_data;
               6'd26, 6'd27, 6'd28, 6'd29: src_ip <= {src_ip[23:0], rx_data};
               6'd30, 6'd31, 6'd32, 6'd33: dst_ip <= {dst_ip[23:0], rx_data};
               default: ;
            endcase
         end
      end
   end

   // Emitter runs independently of the FSM so the pipe drains even after the FSM returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_d1       <= 8'd0;
         payload_data  <= 8'd0;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         pl_rem        <= 16'd0;
         hdr_ok        <= 1'b0;
         hdr_err       <= 1'b0;
      end else begin
         pipe_d1      <= rx_data;
         payload_data <= pipe_d1;
         hdr_ok       <= pl_start;
         hdr_err      <= (state == CHK_CMP) && !hdr_pass;
         if (pl_start) begin
            payload_valid <= dv_q;
            payload_last  <= !rx_dv;
            pl_rem        <= ip_total_len - 16'd21;
         end else if (payload_valid && !payload_last) begin
            pl_rem       <= pl_rem - 16'd1;
            payload_last <= (pl_rem == 16'd1) || !rx_dv;
         end else begin
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ipv4_rx.sv
// tb/tb_ipv4_rx.sv - self-checking bench for ipv4_rx driven by a frame-level model
`timescale 1ns/1ps
module tb_ipv4_rx;
   localparam logic [47:0] LOCAL_MAC = 48'h000a3501fec0;
   localparam logic [31:0] LOCAL_IP  = 32'hc0a80002;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_dv = 1'b0;
   logic [15:0] check_sum;
   logic [3:0]  ip_ver, ip_hdr_len;
   logic [7:0]  ip_tos, ip_ttl, ip_protocol, payload_data;
   logic [15:0] ip_total_len, ip_id;
   logic        ip_rsv, ip_df, ip_mf, cal_en, hdr_ok, hdr_err, payload_valid, payload_last;
   logic [12:0] ip_frag_offset;
   logic [31:0] src_ip, dst_ip;
   logic [47:0] src_mac;

   ipv4_rx dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv),
      .ip_ver(ip_ver), .ip_hdr_len(ip_hdr_len), .ip_tos(ip_tos), .ip_total_len(ip_total_len),
      .ip_id(ip_id), .ip_rsv(ip_rsv), .ip_df(ip_df), .ip_mf(ip_mf),
      .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_protocol(ip_protocol),
      .src_ip(src_ip), .dst_ip(dst_ip), .src_mac(src_mac), .cal_en(cal_en),
      .check_sum(check_sum), .hdr_ok(hdr_ok), .hdr_err(hdr_err),
      .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ip_checksum stand-in: answers one cycle after cal_en with the sum of the frame being sent
   logic        cal_d = 1'b0;
   logic [15:0] frame_csum = 16'h0000;
   always @(posedge clk) cal_d <= cal_en;
   assign check_sum = cal_d ? frame_csum : 16'h0000;

   bit          exp_cal [int];
   bit          exp_ok  [int];
   bit          exp_err [int];
   logic [8:0]  exp_pd  [int];
   logic [191:0] exp_fld [int];

   logic [191:0] fld_act;
   assign fld_act = {ip_ver, ip_hdr_len, ip_tos, ip_total_len, ip_id, ip_rsv, ip_df, ip_mf,
                     ip_frag_offset, ip_ttl, ip_protocol, src_ip, dst_ip, src_mac};

   int pv_total = 0, last_total = 0, last_ok_cyc = -1, last_cal_cyc = -1;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   initial begin : compare
      bit e_cal, e_ok, e_err, e_pv;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("reset_fields", fld_act, 192'd0);
            check("reset_strobes", {179'd0, hdr_ok, hdr_err, cal_en, payload_valid, payload_last,
                                    payload_data}, 192'd0);
         end else begin
            e_cal = exp_cal.exists(cyc) != 0;
            e_ok  = exp_ok.exists(cyc) != 0;
            e_err = exp_err.exists(cyc) != 0;
            e_pv  = exp_pd.exists(cyc) != 0;
            check("cal_en", {191'd0, cal_en}, {191'd0, e_cal});
            check("hdr_ok", {191'd0, hdr_ok}, {191'd0, e_ok});
            check("hdr_err", {191'd0, hdr_err}, {191'd0, e_err});
            check("payload_valid", {191'd0, payload_valid}, {191'd0, e_pv});
            if (e_pv)
               check("payload_last_data", {183'd0, payload_last, payload_data}, {183'd0, exp_pd[cyc]});
            if (exp_fld.exists(cyc))
               check("hdr_fields", fld_act, exp_fld[cyc]);
         end
         if (payload_valid) pv_total++;
         if (payload_valid && payload_last) last_total++;
         if (hdr_ok) last_ok_cyc = cyc;
         if (cal_en) last_cal_cyc = cyc;
      end
   end

   logic [7:0] fb [0:63];
   int         fl;

   function automatic logic [15:0] model_csum();
      logic [31:0] s;
      s = 32'd0;
      for (int i = 14; i < 34; i += 2)
         if (i != 24) s = s + {16'd0, fb[i], fb[i+1]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return ~s[15:0];
   endfunction

   task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] vihl,
                        input logic [15:0] tlen, input logic [7:0] flg, input logic [7:0] proto,
                        input logic [31:0] dip, input logic [15:0] id, input bit corrupt);
      int n;
      logic [15:0] cs;
      logic [31:0] sip;
      sip = 32'hc0a80001;
      n = int'(tlen) - 20;
      for (int i = 0; i < 6; i++) fb[i] = dmac[47-8*i -: 8];
      for (int i = 0; i < 6; i++) fb[6+i] = 8'h02 + 8'(16*i) + id[7:0];
      fb[12] = et[15:8];   fb[13] = et[7:0];
      fb[14] = vihl;       fb[15] = 8'h00;
      fb[16] = tlen[15:8]; fb[17] = tlen[7:0];
      fb[18] = id[15:8];   fb[19] = id[7:0];
      fb[20] = flg;        fb[21] = 8'h00;
      fb[22] = 8'h40;      fb[23] = proto;
      fb[24] = 8'h00;      fb[25] = 8'h00;
      for (int i = 0; i < 4; i++) fb[26+i] = sip[31-8*i -: 8];
      for (int i = 0; i < 4; i++) fb[30+i] = dip[31-8*i -: 8];
      for (int j = 0; j < n; j++) fb[34+j] = 8'(j*7 + 3) ^ id[7:0];
      for (int k = 0; k < 4; k++) fb[34+n+k] = 8'h5a;
      for (int k = 0; k < 4; k++) fb[38+n+k] = 8'hc0 + 8'(k);
      fl = 34 + n + 8;
      cs = model_csum();
      fb[24] = cs[15:8];
      fb[25] = cs[7:0] ^ {7'd0, corrupt};
      frame_csum = cs;
   endtask

   // Expected observable behaviour of one frame starting in cycle s with L bytes under rx_dv
   task automatic model(input int s, input int L);
      logic [47:0] dm;
      logic [15:0] tl;
      bit pass;
      int n, avail;
      dm = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      if (L < 34) return;
      if (!(dm == LOCAL_MAC || dm == 48'hffffffffffff)) return;
      if ({fb[12], fb[13]} != 16'h0800) return;
      exp_cal[s+34] = 1'b1;
      exp_fld[s+36] = {fb[14], fb[15], fb[16], fb[17], fb[18], fb[19], fb[20], fb[21], fb[22],
                       fb[23], fb[26], fb[27], fb[28], fb[29], fb[30], fb[31], fb[32], fb[33],
                       fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
      tl = {fb[16], fb[17]};
      pass = (model_csum() == {fb[24], fb[25]}) && (fb[14] == 8'h45) &&
             ({fb[30], fb[31], fb[32], fb[33]} == LOCAL_IP) && (fb[23] == 8'd17) &&
             (fb[20][5] == 1'b0) && ({fb[20][4:0], fb[21]} == 13'd0) && (tl >= 16'd28);
      if (!pass) begin
         exp_err[s+36] = 1'b1;
         return;
      end
      exp_ok[s+36] = 1'b1;
      n = int'(tl) - 20;
      avail = (L - 34 < n) ? L - 34 : n;
      for (int j = 0; j < avail; j++) exp_pd[s+36+j] = {(j == avail - 1), fb[34+j]};
   endtask

   task automatic kill(input int rc);
      for (int c = rc; c < rc + 64; c++) begin
         if (exp_cal.exists(c)) exp_cal.delete(c);
         if (exp_ok.exists(c))  exp_ok.delete(c);
         if (exp_err.exists(c)) exp_err.delete(c);
         if (exp_pd.exists(c))  exp_pd.delete(c);
         if (exp_fld.exists(c)) exp_fld.delete(c);
      end
   endtask

   task automatic send(input int L, input int rst_at, input int gap, output int s);
      s = 0;
      for (int i = 0; i < L; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            s = cyc;
            model(s, L);
         end
         rx_dv = 1'b1;
         rx_data = fb[i];
         if (i == rst_at) begin
            rst_n = 1'b0;
            kill(cyc);
         end
         if (rst_at >= 0 && i == rst_at + 2) rst_n = 1'b1;
      end
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         rx_dv = 1'b0;
         rx_data = 8'h99;
      end
   endtask

   initial begin : main
      int s, s1, pv0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0001, 1'b0);
      check("model_csum_pin", {176'd0, frame_csum}, {176'd0, 16'hf974});
      send(fl, -1, 2, s1);
      check("f1_cal_latency", 192'(last_cal_cyc - s1), 192'd34);
      check("f1_ok_latency", 192'(last_ok_cyc - s1), 192'd36);
      check("f1_payload_count", 192'(pv_total), 192'd16);
      check("f1_last_count", 192'(last_total), 192'd1);

      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0002, 1'b1);
      send(fl, -1, 1, s);
      check("f2_no_payload", 192'(pv_total), 192'd16);

      build(LOCAL_MAC, 16'h0806, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0003, 1'b0);
      send(fl, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0004, 1'b0);
      send(fl, -1, 1, s);
      check("after_arp_payload", 192'(pv_total), 192'd32);

      build(48'h001122334455, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0005, 1'b0);
      send(fl, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h0006, 1'b0);
      send(fl, -1, 1, s);

      build(48'hffffffffffff, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, 32'hc0a80009, 16'h0007, 1'b0);
      send(fl, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd6, LOCAL_IP, 16'h0008, 1'b0);
      send(fl, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h20, 8'd17, LOCAL_IP, 16'h0009, 1'b0);
      send(fl, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd27, 8'h00, 8'd17, LOCAL_IP, 16'h000a, 1'b0);
      send(fl, -1, 1, s);
      check("rejects_no_payload", 192'(pv_total), 192'd48);

      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h000b, 1'b0);
      send(20, -1, 1, s);

      pv0 = pv_total;
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h000c, 1'b0);
      send(39, -1, 1, s);
      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h000d, 1'b0);
      send(fl, 37, 2, s);
      check("truncated_and_reset_payload", 192'(pv_total - pv0), 192'd6);

      build(LOCAL_MAC, 16'h0800, 8'h45, 16'd36, 8'h00, 8'd17, LOCAL_IP, 16'h000e, 1'b0);
      send(fl, -1, 4, s);
      check("total_payload", 192'(pv_total), 192'd70);
      check("total_last", 192'(last_total), 192'd5);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
